// File: rtl/debug_pkg.sv
// ---------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug single-step controller:
//   - ctrl_state_t  : FSM state encoding (also exported on ctrl_state)
//   - DB_CYCLES_DEF : default debounce hold time in clock cycles
//   - CNT_W_DEF     : default width of the completed-step counter
//   - cpu_en_of()   : which states let the CPU pipeline advance
// ---------------------------------------------------------------------------
package debug_pkg;

   typedef enum logic [1:0] {
      ST_HALT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STEP     = 2'd2,
      ST_WAIT_REL = 2'd3
   } ctrl_state_t;

   localparam int DB_CYCLES_DEF = 4;
   localparam int CNT_W_DEF     = 16;

   // The pipeline advances only while free-running or executing a step.
   function automatic logic cpu_en_of(input ctrl_state_t s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/step_debounce.sv
// ---------------------------------------------------------------------------
// step_debounce
// Conditions the raw step button: 2-flop synchronizer, hold-time debouncer
// and rising-edge detector.
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active low
//   step_raw  in   raw, asynchronous, bouncing button level
//   step_req  out  one-cycle pulse per debounced 0->1 transition
//   db_level  out  current debounced button level
// ---------------------------------------------------------------------------
module step_debounce
   import debug_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic step_raw,
   output logic step_req,
   output logic db_level
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic [CW-1:0] db_cnt;
   logic          db_level_q;
   logic          db_level_prev;

   // ---- synchronizer stage ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= step_raw;
         sync_p1 <= sync_p0;
      end
   end

   // ---- debounce stage ----
   // The level flips on the DB_CYCLES-th consecutive disagreeing cycle;
   // a single agreeing cycle restarts the count from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt        <= '0;
         db_level_q    <= 1'b0;
         db_level_prev <= 1'b0;
      end else begin
         db_level_prev <= db_level_q;
         if (sync_p1 != db_level_q) begin
            if (db_cnt == CNT_LAST) begin
               db_level_q <= sync_p1;
               db_cnt     <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // ---- edge detect ----
   assign step_req = db_level_q & ~db_level_prev;
   assign db_level = db_level_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// debug_step_ctrl
// Run / single-step controller for a CPU pipeline. In free-run mode the
// pipeline is enabled every cycle; in debug mode each debounced press of the
// step button lets exactly one non-stalled pipeline cycle through.
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous reset, active low
//   debug_en    in   1 = single-step mode, 0 = free-run
//   debug_step  in   raw step button (asynchronous, bouncing)
//   cpu_stall   in   pipeline cannot advance this cycle
//   cpu_en      out  registered pipeline advance enable
//   step_count  out  completed single steps, wraps at 2^CNT_W
//   ctrl_state  out  current FSM state (debug_pkg::ctrl_state_t)
// ---------------------------------------------------------------------------
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             debug_en,
   input  logic             debug_step,
   input  logic             cpu_stall,
   output logic             cpu_en,
   output logic [CNT_W-1:0] step_count,
   output logic [1:0]       ctrl_state
);

   ctrl_state_t state_q;
   ctrl_state_t state_nxt;
   logic        cpu_en_nxt;
   logic        step_commit;
   logic        step_req;
   logic        db_level;

   step_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_step_debounce (
      .clk      (clk),
      .rst      (rst),
      .step_raw (debug_step),
      .step_req (step_req),
      .db_level (db_level)
   );

   // ---- state / output register stage ----
   // cpu_en is loaded from the decode of the next state, so it always equals
   // the decode of state_q while remaining a glitch-free flop output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_HALT;
         cpu_en     <= 1'b0;
         step_count <= '0;
      end else begin
         state_q <= state_nxt;
         cpu_en  <= cpu_en_nxt;
         if (step_commit) begin
            step_count <= step_count + 1'b1;
         end
      end
   end

   // Next-state logic. A step already in flight always commits before the
   // FSM looks at debug_en again; step_req outside HALT is simply dropped.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_HALT: begin
            if (!debug_en) begin
               state_nxt = ST_RUN;
            end else if (step_req) begin
               state_nxt = ST_STEP;
            end
         end
         ST_RUN: begin
            if (debug_en) begin
               state_nxt = ST_HALT;
            end
         end
         ST_STEP: begin
            if (!cpu_stall) begin
               state_nxt = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            if (!db_level) begin
               state_nxt = debug_en ? ST_HALT : ST_RUN;
            end
         end
         default: state_nxt = ST_HALT;
      endcase
   end

   // Output decode.
   always_comb begin
      cpu_en_nxt  = cpu_en_of(state_nxt);
      step_commit = (state_q == ST_STEP) && !cpu_stall;
   end

   assign ctrl_state = state_q;

endmodule
